// File: rtl/axil_regbank_pkg.sv
// Shared types and helpers for the AXI4-Lite register bank.
// Response codes, FSM state enums, register modes, address decode.
package axil_regbank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_ACCEPT, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  typedef enum logic [1:0] {
    MODE_RW,
    MODE_RO,
    MODE_W1C
  } reg_mode_t;

  // Drop the byte-offset bits to get a register index.
  function automatic logic [31:0] addr2idx(
    input logic [31:0] addr,
    input int unsigned lsb
  );
    return addr >> lsb;
  endfunction

endpackage

// File: rtl/axil_reg_cell.sv
// One register of the bank: RW (byte-strobed), RO (tracks hw) or W1C.
// Ports: clk/rst_n, i_we/i_strb/i_data write, i_hw_set, i_hw_val, o_q.
module axil_reg_cell
  import axil_regbank_pkg::*;
#(
  parameter int        DW   = 32,
  parameter reg_mode_t MODE = MODE_RW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_we,
  input  logic [DW/8-1:0] i_strb,
  input  logic [DW-1:0]   i_data,
  input  logic [DW-1:0]   i_hw_set,
  input  logic [DW-1:0]   i_hw_val,
  output logic [DW-1:0]   o_q
);

  logic [DW-1:0] w_mask;
  logic [DW-1:0] r_q;

  always_comb begin
    w_mask = '0;
    for (int b = 0; b < DW/8; b++) begin
      w_mask[b*8 +: 8] = {8{i_we & i_strb[b]}};
    end
  end

  // For W1C the set term is ORed last so a same-edge set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else begin
      unique case (MODE)
        MODE_RO:  r_q <= i_hw_val;
        MODE_W1C: r_q <= (r_q & ~(i_data & w_mask)) | i_hw_set;
        default:  r_q <= (r_q & ~w_mask) | (i_data & w_mask);
      endcase
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/axil_regbank_slave.sv
// AXI4-Lite slave register bank with RW/RO/W1C registers and irq.
// Ports: S_AXI_* bus, hw_status_in, hw_set, reg_out, wr_pulse, irq.
module axil_regbank_slave
  import axil_regbank_pkg::*;
#(
  parameter int                  C_S_AXI_DATA_WIDTH = 32,
  parameter int                  C_S_AXI_ADDR_WIDTH = 6,
  parameter int                  NUM_REGS           = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK            = '0,
  parameter logic [NUM_REGS-1:0] W1C_MASK           = '0
) (
  input  logic                             S_AXI_ACLK,
  input  logic                             S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]    S_AXI_AWADDR,
  input  logic [2:0]                       S_AXI_AWPROT,
  input  logic                             S_AXI_AWVALID,
  output logic                             S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]    S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]  S_AXI_WSTRB,
  input  logic                             S_AXI_WVALID,
  output logic                             S_AXI_WREADY,
  output logic [1:0]                       S_AXI_BRESP,
  output logic                             S_AXI_BVALID,
  input  logic                             S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]    S_AXI_ARADDR,
  input  logic [2:0]                       S_AXI_ARPROT,
  input  logic                             S_AXI_ARVALID,
  output logic                             S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]    S_AXI_RDATA,
  output logic [1:0]                       S_AXI_RRESP,
  output logic                             S_AXI_RVALID,
  input  logic                             S_AXI_RREADY,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] hw_status_in,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] hw_set,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]              wr_pulse,
  output logic                             irq
);

  localparam int          DW  = C_S_AXI_DATA_WIDTH;
  localparam int          AW  = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned LSB = $clog2(DW/8);

  wr_state_t       r_wstate, w_wstate_n;
  rd_state_t       r_rstate, w_rstate_n;
  logic            r_aw_held, w_aw_held_n;
  logic            r_w_held, w_w_held_n;
  logic [AW-1:0]   r_awaddr;
  logic [DW-1:0]   r_wdata;
  logic [DW/8-1:0] r_wstrb;
  logic            r_awready, w_awready_n;
  logic            r_wready, w_wready_n;
  logic            r_bvalid, w_bvalid_n;
  logic [1:0]      r_bresp, w_bresp_n;
  logic            r_arready, w_arready_n;
  logic            r_rvalid, w_rvalid_n;
  logic [DW-1:0]   r_rdata, w_rdata_n;
  logic [1:0]      r_rresp, w_rresp_n;
  logic [NUM_REGS-1:0] r_wr_pulse, w_we;
  logic            r_irq, w_irq_n;
  logic            w_commit;
  logic            w_wr_ok;
  logic [DW-1:0]   w_q [NUM_REGS];
  logic            w_unused;

  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  wire w_aw_hs   = S_AXI_AWVALID & r_awready;
  wire w_w_hs    = S_AXI_WVALID & r_wready;
  wire w_aw_have = r_aw_held | w_aw_hs;
  wire w_w_have  = r_w_held | w_w_hs;
  wire w_ar_hs   = S_AXI_ARVALID & r_arready;

  // Latched values take priority; otherwise use the live bus.
  wire [AW-1:0]   w_waddr = r_aw_held ? r_awaddr : S_AXI_AWADDR;
  wire [DW-1:0]   w_wdata = r_w_held ? r_wdata : S_AXI_WDATA;
  wire [DW/8-1:0] w_wstrb = r_w_held ? r_wstrb : S_AXI_WSTRB;
  wire [31:0]     w_widx  = addr2idx(32'(w_waddr), LSB);
  wire [31:0]     w_ridx  = addr2idx(32'(S_AXI_ARADDR), LSB);

  always_comb begin
    w_wr_ok = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_widx == 32'(i)) w_wr_ok = !RO_MASK[i];
    end
  end

  always_comb begin
    w_wstate_n  = r_wstate;
    w_aw_held_n = r_aw_held;
    w_w_held_n  = r_w_held;
    w_awready_n = r_awready;
    w_wready_n  = r_wready;
    w_bvalid_n  = r_bvalid;
    w_bresp_n   = r_bresp;
    w_commit    = 1'b0;
    unique case (r_wstate)
      W_ACCEPT: begin
        if (w_aw_have && w_w_have) begin
          w_commit    = 1'b1;
          w_wstate_n  = W_RESP;
          w_aw_held_n = 1'b0;
          w_w_held_n  = 1'b0;
          w_awready_n = 1'b0;
          w_wready_n  = 1'b0;
          w_bvalid_n  = 1'b1;
          w_bresp_n   = w_wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else begin
          w_aw_held_n = w_aw_have;
          w_w_held_n  = w_w_have;
          w_awready_n = !w_aw_have;
          w_wready_n  = !w_w_have;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) begin
          w_wstate_n  = W_ACCEPT;
          w_bvalid_n  = 1'b0;
          w_awready_n = 1'b1;
          w_wready_n  = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    w_we = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_we[i] = w_commit && w_wr_ok && (w_widx == 32'(i));
    end
  end

  // Read mux sees pre-edge register values, so a colliding
  // write on the same edge is not visible to the read.
  always_comb begin
    w_rdata_n = '0;
    w_rresp_n = RESP_SLVERR;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_ridx == 32'(i)) begin
        w_rresp_n = RESP_OKAY;
        w_rdata_n = RO_MASK[i] ? hw_status_in[i*DW +: DW] : w_q[i];
      end
    end
  end

  always_comb begin
    w_rstate_n  = r_rstate;
    w_rvalid_n  = r_rvalid;
    w_arready_n = r_arready;
    unique case (r_rstate)
      R_IDLE: begin
        w_arready_n = 1'b1;
        if (w_ar_hs) begin
          w_rstate_n  = R_DATA;
          w_rvalid_n  = 1'b1;
          w_arready_n = 1'b0;
        end
      end
      R_DATA: begin
        if (S_AXI_RREADY) begin
          w_rstate_n  = R_IDLE;
          w_rvalid_n  = 1'b0;
          w_arready_n = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    w_irq_n = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (W1C_MASK[i]) w_irq_n = w_irq_n | (|w_q[i]);
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_wstate   <= W_ACCEPT;
      r_rstate   <= R_IDLE;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
      r_wr_pulse <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_wstate   <= w_wstate_n;
      r_rstate   <= w_rstate_n;
      r_aw_held  <= w_aw_held_n;
      r_w_held   <= w_w_held_n;
      r_awready  <= w_awready_n;
      r_wready   <= w_wready_n;
      r_bvalid   <= w_bvalid_n;
      r_bresp    <= w_bresp_n;
      r_arready  <= w_arready_n;
      r_rvalid   <= w_rvalid_n;
      r_wr_pulse <= w_we;
      r_irq      <= w_irq_n;
      if (w_aw_hs) r_awaddr <= S_AXI_AWADDR;
      if (w_w_hs) begin
        r_wdata <= S_AXI_WDATA;
        r_wstrb <= S_AXI_WSTRB;
      end
      if (w_ar_hs) begin
        r_rdata <= w_rdata_n;
        r_rresp <= w_rresp_n;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    localparam reg_mode_t M = RO_MASK[g]  ? MODE_RO  :
                              W1C_MASK[g] ? MODE_W1C : MODE_RW;
    axil_reg_cell #(
      .DW   (DW),
      .MODE (M)
    ) u_cell (
      .clk      (S_AXI_ACLK),
      .rst_n    (S_AXI_ARESETN),
      .i_we     (w_we[g]),
      .i_strb   (w_wstrb),
      .i_data   (w_wdata),
      .i_hw_set (hw_set[g*DW +: DW]),
      .i_hw_val (hw_status_in[g*DW +: DW]),
      .o_q      (w_q[g])
    );
    assign reg_out[g*DW +: DW] = w_q[g];
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = r_rresp;
  assign wr_pulse      = r_wr_pulse;
  assign irq           = r_irq;

endmodule

// File: tb/tb_axil_regbank_slave.sv
// Directed scoreboard bench for axil_regbank_slave.
// Config: DW=32, 8 regs, reg7 RO, reg6 W1C.
module tb_axil_regbank_slave;
  import axil_regbank_pkg::*;

  logic         clk = 0;
  logic         rst_n = 0;
  logic [5:0]   awaddr = 0, araddr = 0;
  logic [2:0]   awprot = 0, arprot = 0;
  logic         awvalid = 0, wvalid = 0, bready = 0;
  logic         arvalid = 0, rready = 0;
  logic [31:0]  wdata = 0;
  logic [3:0]   wstrb = 0;
  logic [255:0] hw_status = 0, hw_set = 0;
  wire          awready, wready, bvalid, arready, rvalid, irq;
  wire  [1:0]   bresp, rresp;
  wire  [31:0]  rdata;
  wire  [255:0] reg_out;
  wire  [7:0]   wr_pulse;

  axil_regbank_slave #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (6),
    .NUM_REGS           (8),
    .RO_MASK            (8'h80),
    .W1C_MASK           (8'h40)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .hw_status_in  (hw_status),
    .hw_set        (hw_set),
    .reg_out       (reg_out),
    .wr_pulse      (wr_pulse),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  int          pulse_cnt [8];
  logic [31:0] mdl [8];
  logic [1:0]  bq [$];
  logic [33:0] rq [$];

  initial for (int i = 0; i < 8; i++) pulse_cnt[i] = 0;

  always @(posedge clk)
    for (int i = 0; i < 8; i++)
      if (wr_pulse[i] === 1'b1) pulse_cnt[i]++;

  initial begin
    #500000;
    $display("FAIL watchdog: no finish after 500us");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input logic [5:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [31:0] hs);
    int unsigned idx = 32'(a) >> 2;
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{s[b]}};
    if (idx >= 8 || idx == 7) begin
      bq.push_back(RESP_SLVERR);
    end else begin
      if (idx == 6) mdl[6] = (mdl[6] & ~(d & m)) | hs;
      else mdl[idx] = (mdl[idx] & ~m) | (d & m);
      bq.push_back(RESP_OKAY);
    end
  endtask

  task automatic model_read(input logic [5:0] a);
    int unsigned idx = 32'(a) >> 2;
    if (idx >= 8) rq.push_back({RESP_SLVERR, 32'h0});
    else if (idx == 7) rq.push_back({RESP_OKAY, hw_status[7*32 +: 32]});
    else rq.push_back({RESP_OKAY, mdl[idx]});
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [31:0] hs,
                           input string tag);
    int t = 0;
    logic aw_hs, w_hs;
    logic [1:0] e;
    model_write(a, d, s, hs);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1; wvalid = 1;
    hw_set[6*32 +: 32] = hs;
    while ((awvalid || wvalid) && t < 20) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      step();
      hw_set = '0;
      if (aw_hs) awvalid = 0;
      if (w_hs) wvalid = 0;
      t++;
    end
    chk({tag, "_hs"}, {awvalid, wvalid}, 0);
    awvalid = 0; wvalid = 0;
    bready = 1; t = 0;
    while (!bvalid && t < 20) begin step(); t++; end
    e = bq.pop_front();
    chk({tag, "_b"}, {bvalid, bresp}, {1'b1, e});
    step();
    bready = 0;
  endtask

  task automatic axi_read(input logic [5:0] a, input string tag);
    int t = 0;
    logic hs;
    logic [33:0] e;
    model_read(a);
    araddr = a; arvalid = 1;
    while (arvalid && t < 20) begin
      hs = arready;
      step();
      if (hs) arvalid = 0;
      t++;
    end
    chk({tag, "_ar"}, arvalid, 0);
    arvalid = 0;
    rready = 1; t = 0;
    while (!rvalid && t < 20) begin step(); t++; end
    e = rq.pop_front();
    chk({tag, "_r"}, {rvalid, rresp, rdata}, {1'b1, e});
    step();
    rready = 0;
  endtask

  initial begin
    logic [1:0] e;
    for (int i = 0; i < 8; i++) mdl[i] = 0;
    hw_status[7*32 +: 32] = 32'hCAFE0001;

    step(); step();
    chk("rst_flags",
        {awready, wready, arready, bvalid, rvalid, bresp, rresp,
         wr_pulse, irq}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_regout", |reg_out, 0);
    rst_n = 1;
    step();
    chk("rel_ready", {awready, wready, arready}, 3'b111);

    for (int i = 0; i < 4; i++)
      axi_write(6'(i * 4), 32'(i + 1), 4'hF, 0, "seq_wr");
    for (int i = 0; i < 4; i++)
      axi_read(6'(i * 4), "seq_rd");
    for (int i = 0; i < 4; i++)
      chk("seq_pulse", pulse_cnt[i], 1);
    chk("seq_regout2", reg_out[2*32 +: 32], 32'h3);

    axi_write(6'h0, 32'h11223344, 4'hF, 0, "strb_wr0");
    axi_write(6'h0, 32'hAABBCCDD, 4'b0101, 0, "strb_wr1");
    axi_read(6'h0, "strb_rd");

    model_write(6'h4, 32'h55, 4'hF, 0);
    awaddr = 6'h4; wdata = 32'h55; wstrb = 4'hF;
    wvalid = 1;
    chk("wo_wready_pre", wready, 1);
    step();
    wvalid = 0;
    chk("wo_wready_drop", {wready, awready, bvalid}, 3'b010);
    step(); step();
    awvalid = 1;
    chk("wo_bvalid_pre", bvalid, 0);
    step();
    awvalid = 0;
    e = bq.pop_front();
    chk("wo_bvalid", {bvalid, bresp}, {1'b1, e});
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold", {bvalid, bresp, awready, wready}, {1'b1, e, 2'b00});
    end
    bready = 1;
    step();
    bready = 0;
    chk("bp_release", {bvalid, awready, wready}, 3'b011);
    axi_read(6'h4, "wo_rd");

    axi_read(6'h20, "err_rd");
    axi_write(6'h1C, 32'h12345678, 4'hF, 0, "ro_wr");
    axi_read(6'h1C, "ro_rd");

    hw_set[6*32 +: 32] = 32'h5;
    mdl[6] = mdl[6] | 32'h5;
    step();
    hw_set = '0;
    step();
    chk("w1c_irq_set", irq, 1);
    axi_read(6'h18, "w1c_rd5");
    axi_write(6'h18, 32'h1, 4'hF, 0, "w1c_clr1");
    axi_read(6'h18, "w1c_rd4");
    axi_write(6'h18, 32'h4, 4'hF, 32'h4, "w1c_setclr");
    axi_read(6'h18, "w1c_rd_keep");
    chk("w1c_irq_keep", irq, 1);
    axi_write(6'h18, 32'h4, 4'hF, 0, "w1c_clr4");
    axi_read(6'h18, "w1c_rd0");
    chk("w1c_irq_clr", irq, 0);

    awaddr = 6'h8; wdata = 32'h99; wstrb = 4'hF;
    araddr = 6'h0;
    awvalid = 1; wvalid = 1; arvalid = 1;
    step();
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("mid_pre", {bvalid, rvalid}, 2'b11);
    #2;
    rst_n = 0;
    #1;
    chk("mid_rst_flags", {bvalid, rvalid, awready, wready, arready}, 0);
    chk("mid_rst_regout", |reg_out, 0);
    for (int i = 0; i < 8; i++) mdl[i] = 0;
    step(); step();
    rst_n = 1;
    step();
    axi_write(6'h8, 32'h77, 4'hF, 0, "post_wr");
    axi_read(6'h8, "post_rd8");
    axi_read(6'h0, "post_rd0");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
